multicycle_control_unit: RTL
============================

# multicycle_control_unit

Sequenced control unit for the multicycle MIPS datapath. It decodes the fetched instruction into the datapath control bundle and sequences FETCH/DECODE/EXEC/MEM/WB through a state machine. It holds memory requests until the cache/memory arbiter answers with `ihit`/`dhit`, and stops with an error flag if a request is never answered. It sits between the instruction register and the datapath, replacing the single-cycle combinational control unit.

## Interface
- `WORD_W`, 32: instruction/data word width; must match `word_t`.
- `TIMEOUT_CYCLES`, 255: maximum cycles a memory request may wait for a hit before error halt; range 1 to 2^`TIMEOUT_W`-1.
- `TIMEOUT_W`, 8: width of the wait watchdog counter.
- `CLK`  in  1  single clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `instruction`  in  `WORD_W`  current instruction-register contents.
- `ihit` / `dhit`  in  1 each  instruction / data request completed this cycle.
- `zero`, `overflow`  in  1 each  ALU flags, valid in EXEC.
- `iREN`, `dREN`, `dWEN`  out  1 each  memory requests.
- `ir_en`, `pc_en`  out  1 each  load instruction register; load PC.
- `WEN`  out  1  register-file write.
- `ALUSrc`, `RegDest`, `MemReg`, `sign_ext`, `lui`, `shamt_en`, `j`, `jr`, `jal`, `PCSrc`  out  1 each  datapath selects.
- `ALUcode`  out  `aluop_t`  ALU operation.
- `halt`  out  1  core halted (sticky).
- `err`  out  1  halted due to timeout or illegal opcode (sticky).
- `state`  out  `ctrl_state_t`  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset values: state=IDLE, watchdog=0, `halt`=0, `err`=0. Every output is 0 and `ALUcode`=ALU_SLL.
- IDLE: one cycle, then FETCH.
- FETCH: `iREN`=1 until `ihit`. On `ihit`, `ir_en`=1 and `pc_en`=1 (PC+4), then go to DECODE.
- DECODE: one cycle. HALT opcode (0x3F) goes to HALT. An unrecognised opcode/funct goes to HALT with `err`=1. Otherwise go to EXEC.
- EXEC: one cycle. `ALUcode` and the selects are valid.
  - BEQ/BNE: `PCSrc` = `zero` (BEQ) or `!zero` (BNE); `pc_en`=`PCSrc`.
  - J/JR: `pc_en`=1.
  - Next state after EXEC: LW/SW go to MEM; R-type, I-type ALU and JAL go to WB; branches, J and JR go to FETCH.
- MEM: LW holds `dREN`=1 and SW holds `dWEN`=1 until `dhit`. Then LW goes to WB and SW goes to FETCH.
- WB: `WEN`=1 for exactly one cycle, then FETCH.
- HALT: absorbing; `halt`=1. Only `nRST` exits.
- Decode outputs are combinational from `instruction`, gated by state: `WEN` only in WB, `dREN`/`dWEN` only in MEM, `iREN` only in FETCH.
- Watchdog:
  - Counts cycles spent in FETCH/MEM without a hit and clears on each state entry.
  - When it reaches `TIMEOUT_CYCLES` with no hit, the next state is HALT with `err`=1.
  - A hit arriving in the same cycle as the timeout wins.
- Simultaneous `ihit` and `dhit`: only the hit relevant to the current state is used.
- `nRST` asserted mid-request drops all requests immediately (asynchronous).

## Timing
- Latency with a zero-wait hit (hit in the first request cycle):
  - R-type: 4 cycles, FETCH to WB.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/J/JR: 3 cycles.
- Each wait cycle on a hit adds one cycle.
- `ir_en`/`pc_en` are single-cycle pulses and are never asserted in HALT.

## Configuration
- `OVERFLOW_TRAP_EN` defined: `overflow`=1 in EXEC on ADD/ADDI/SUB suppresses WB (`WEN` stays 0) and the next state is HALT with `err`=1.
- `OVERFLOW_TRAP_EN` undefined: `overflow` is ignored; signed ops write back normally.

## Structure
- `cpu_types_pkg` gains `ctrl_state_t` (enum, 3 bits). It already provides `opcode_t`, `funct_t`, `aluop_t` and `word_t`.
- `HALT_OP` (0x3F) stays in `cpu_types_pkg`.
- Sub-module `control_decode`: purely combinational instruction-to-control-bundle decoder with an `illegal` output. The FSM, watchdog and gating live in the top block.

## Test plan
- Reset, then ADDU $3,$1,$2 with `ihit` on the first FETCH cycle → states IDLE,FETCH,DECODE,EXEC,WB; `WEN`=1 for exactly one cycle in WB; `ALUcode`=ALU_ADD.
- LW with `dhit` delayed 3 cycles → `dREN` high for 4 cycles, then `WEN`=1 with `MemReg`=1; total 8 cycles from FETCH.
- BEQ with `zero`=1 → `PCSrc`=1 and `pc_en`=1 in EXEC; with `zero`=0 → `pc_en`=0 in EXEC; both return to FETCH.
- `ihit` withheld with `TIMEOUT_CYCLES`=4 → HALT after 4 FETCH cycles; `halt`=1, `err`=1, `iREN`=0.
- Opcode 0x3F → HALT after DECODE with `err`=0; `nRST` low for 1 cycle → IDLE with `halt`=0.
- ADD with `overflow`=1 → macro defined: `WEN` never asserted, `err`=1; macro undefined: `WEN`=1 in WB.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle MIPS core: opcodes, functs, ALU ops,
// the control FSM state encoding and the decoded control bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT_OP = 6'h3F;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = HALT_OP
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } ctrl_state_t;

  typedef struct packed {
    logic   alu_src;
    logic   reg_dest;
    logic   mem_reg;
    logic   sign_ext;
    logic   lui;
    logic   shamt_en;
    logic   j;
    logic   jr;
    logic   jal;
    logic   branch;
    logic   bne;
    logic   mem_read;
    logic   mem_write;
    logic   reg_write;
    logic   ovf_op;
    logic   halt_op;
    aluop_t aluop;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: maps an instruction word to the
// datapath control bundle and flags unrecognised opcode/funct encodings.
module control_decode
  import cpu_types_pkg::*;
(
  input  word_t instruction,
  output ctrl_t ctrl,
  output logic  illegal
);

  logic unused_fields;
  assign unused_fields = ^instruction[25:6];

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALU_SLL;
    illegal    = 1'b0;
    case (opcode_t'(instruction[31:26]))
      OP_RTYPE: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct_t'(instruction[5:0]))
          FN_SLL:  begin ctrl.shamt_en = 1'b1; ctrl.aluop = ALU_SLL; end
          FN_SRL:  begin ctrl.shamt_en = 1'b1; ctrl.aluop = ALU_SRL; end
          FN_JR:   begin ctrl.jr = 1'b1; ctrl.reg_write = 1'b0; end
          FN_ADD:  begin ctrl.aluop = ALU_ADD; ctrl.ovf_op = 1'b1; end
          FN_ADDU: ctrl.aluop = ALU_ADD;
          FN_SUB:  begin ctrl.aluop = ALU_SUB; ctrl.ovf_op = 1'b1; end
          FN_SUBU: ctrl.aluop = ALU_SUB;
          FN_AND:  ctrl.aluop = ALU_AND;
          FN_OR:   ctrl.aluop = ALU_OR;
          FN_XOR:  ctrl.aluop = ALU_XOR;
          FN_NOR:  ctrl.aluop = ALU_NOR;
          FN_SLT:  ctrl.aluop = ALU_SLT;
          FN_SLTU: ctrl.aluop = ALU_SLTU;
          default: begin ctrl.reg_write = 1'b0; illegal = 1'b1; end
        endcase
      end
      OP_J: ctrl.j = 1'b1;
      OP_JAL: begin
        ctrl.j         = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.bne      = instruction[26];
        ctrl.sign_ext = 1'b1;
        ctrl.aluop    = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.aluop     = ALU_ADD;
        ctrl.ovf_op    = ~instruction[26];
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.aluop     = instruction[26] ? ALU_SLTU : ALU_SLT;
      end
      OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.aluop = ALU_AND; end
      OP_ORI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.aluop = ALU_OR;  end
      OP_XORI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.aluop = ALU_XOR; end
      OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.lui       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
        ctrl.mem_reg   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.aluop     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.aluop     = ALU_ADD;
      end
      OP_HALT: ctrl.halt_op = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM with memory-wait watchdog and sticky halt/err.
// Optional feature macro: OVERFLOW_TRAP_EN (signed-overflow trap in EXEC).
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instruction,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  input  logic              overflow,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              ir_en,
  output logic              pc_en,
  output logic              WEN,
  output logic              ALUSrc,
  output logic              RegDest,
  output logic              MemReg,
  output logic              sign_ext,
  output logic              lui,
  output logic              shamt_en,
  output logic              j,
  output logic              jr,
  output logic              jal,
  output logic              PCSrc,
  output aluop_t            ALUcode,
  output logic              halt,
  output logic              err,
  output ctrl_state_t       state
);

  ctrl_t                dec;
  logic                 illegal;
  ctrl_state_t          next_state;
  logic                 err_set;
  logic                 trap;
  logic                 timeout;
  logic                 take;
  logic [TIMEOUT_W-1:0] wd;

  control_decode u_decode (
    .instruction (instruction),
    .ctrl        (dec),
    .illegal     (illegal)
  );

`ifdef OVERFLOW_TRAP_EN
  assign trap = dec.ovf_op & overflow;
`else
  logic unused_ovf;
  assign unused_ovf = dec.ovf_op ^ overflow;
  assign trap       = 1'b0;
`endif

  // wd holds the wait cycles already spent, so the current cycle is wait number wd+1
  assign timeout = (wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign halt    = (state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (err_set) err <= 1'b1;
      if (next_state == state && (state == FETCH || state == MEM))
        wd <= wd + 1'b1;
      else
        wd <= '0;
    end
  end

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    take       = 1'b0;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    WEN        = 1'b0;
    ALUSrc     = 1'b0;
    RegDest    = 1'b0;
    MemReg     = 1'b0;
    sign_ext   = 1'b0;
    lui        = 1'b0;
    shamt_en   = 1'b0;
    j          = 1'b0;
    jr         = 1'b0;
    jal        = 1'b0;
    PCSrc      = 1'b0;
    ALUcode    = ALU_SLL;

    // Selects follow the IR only once it holds a fetched instruction
    if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
      ALUSrc   = dec.alu_src;
      RegDest  = dec.reg_dest;
      MemReg   = dec.mem_reg;
      sign_ext = dec.sign_ext;
      lui      = dec.lui;
      shamt_en = dec.shamt_en;
      j        = dec.j;
      jr       = dec.jr;
      jal      = dec.jal;
      ALUcode  = dec.aluop;
    end

    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_en      = 1'b1;
          pc_en      = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          next_state = HALT;
          err_set    = 1'b1;
        end
      end
      DECODE: begin
        if (dec.halt_op) begin
          next_state = HALT;
        end else if (illegal) begin
          next_state = HALT;
          err_set    = 1'b1;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (dec.branch) begin
          take  = dec.bne ? ~zero : zero;
          PCSrc = take;
          pc_en = take;
        end else if (dec.j | dec.jr) begin
          pc_en = 1'b1;
        end
        if (trap) begin
          next_state = HALT;
          err_set    = 1'b1;
        end else if (dec.mem_read | dec.mem_write) begin
          next_state = MEM;
        end else if (dec.reg_write) begin
          next_state = WB;
        end else begin
          next_state = FETCH;
        end
      end
      MEM: begin
        dREN = dec.mem_read;
        dWEN = ~dec.mem_read;
        if (dhit) begin
          next_state = dec.mem_read ? WB : FETCH;
        end else if (timeout) begin
          next_state = HALT;
          err_set    = 1'b1;
        end
      end
      WB: begin
        WEN        = 1'b1;
        next_state = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

endmodule
